// File: rtl/rvfi_channel_serializer.sv
// rvfi_channel_serializer
// Serializes an NRET-wide RVFI retire stream into one retirement per cycle,
// preserving program order (channel 0 oldest). Bursts are absorbed in a
// DEPTH-entry register FIFO; overflow drops and channel-ordering holes are
// flagged with sticky bits, and the occupancy high-water mark is tracked.
//
// Ports:
//   clk        : clock, all state updates on rising edge
//   resetn     : asynchronous active-low reset
//   in_valid   : per-channel retire valid (NRET bits)
//   in_data    : per-channel packets, channel i at [i*W +: W]
//   out_ready  : consumer accepts the head this cycle
//   out_valid  : FIFO head valid (registered state only)
//   out_data   : FIFO head packet, don't-care while out_valid=0
//   count      : current occupancy
//   high_water : maximum occupancy since reset
//   overflow   : sticky, at least one packet dropped
//   proto_err  : sticky, a valid channel followed an invalid lower channel
module rvfi_channel_serializer #(
   parameter int unsigned NRET  = 2,
   parameter int unsigned W     = 128,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [NRET-1:0]            in_valid,
   input  logic [NRET*W-1:0]          in_data,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [W-1:0]               out_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic [$clog2(DEPTH):0]     high_water,
   output logic                       overflow,
   output logic                       proto_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]    mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;

   logic            pop;
   logic [CW-1:0]   free;
   logic [CW-1:0]   n_wr;
   logic [CW-1:0]   count_next;
   logic [NRET-1:0] take;
   logic [AW-1:0]   off [NRET];
   logic            drop;
   logic            hole;
   logic            order_bad;

   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];

   // Channels are packed densely: each accepted channel lands at the slot
   // offset equal to the number of channels accepted before it, so a hole
   // in in_valid does not leave a gap in the FIFO.
   always_comb begin
      pop        = out_valid && out_ready;
      free       = CW'(DEPTH) - count + CW'(pop);
      n_wr       = '0;
      take       = '0;
      drop       = 1'b0;
      hole       = 1'b0;
      order_bad  = 1'b0;
      for (int unsigned i = 0; i < NRET; i++) begin
         off[i] = n_wr[AW-1:0];
         if (in_valid[i]) begin
            if (hole) begin
               order_bad = 1'b1;
            end
            if (n_wr < free) begin
               take[i] = 1'b1;
               n_wr    = n_wr + CW'(1);
            end else begin
               drop = 1'b1;
            end
         end else begin
            hole = 1'b1;
         end
      end
      count_next = count + n_wr - CW'(pop);
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NRET; i++) begin
         if (take[i]) begin
            mem[wr_ptr + off[i]] <= in_data[i*W +: W];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         high_water <= '0;
         overflow   <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         wr_ptr     <= wr_ptr + n_wr[AW-1:0];
         count      <= count_next;
         high_water <= (count_next > high_water) ? count_next : high_water;
         if (drop) begin
            overflow <= 1'b1;
         end
         if (order_bad) begin
            proto_err <= 1'b1;
         end
      end
   end

endmodule
